alu: RTL and testbench



---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_addsub.sv | 43 ++++
 rtl/alu.sv | 126 ++++++++++++
 tb/tb_alu.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared operation encoding and constants for the registered ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Operation select encoding (only the low four bits carry the opcode;
    // the ALU separately checks that every upper Op bit is zero).
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOR  = 4'd5,
        OP_SLL  = 4'd6,
        OP_SRL  = 4'd7,
        OP_SRA  = 4'd8,
        OP_SLT  = 4'd9,
        OP_SLTU = 4'd10,
        OP_MUL  = 4'd11
    } alu_op_e;

    // Highest legal opcode value.
    localparam int OP_LAST = 11;

    // Default datapath width and the matching shift-amount width.
    localparam int DEF_WIDTH = 32;
    localparam int SHAMT_W   = $clog2(DEF_WIDTH);

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_addsub.sv
`default_nettype none
// ============================================================================
// Module      : alu_addsub
// Description : Shared WIDTH+1-bit adder for ADD/SUB/SLT/SLTU. Subtraction is
//               done as A + ~B + 1; produces sum, carry/borrow, signed
//               overflow and both less-than results.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o,
    output logic             lt_signed_o,
    output logic             lt_unsigned_o
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_ext;
    logic             cout;

    // Single adder; inverting B and injecting a carry-in turns it into A-B.
    always_comb begin
        b_eff   = sub_i ? ~b_i : b_i;
        sum_ext = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_i};
        cout    = sum_ext[WIDTH];
        sum_o   = sum_ext[WIDTH-1:0];
        // For subtraction the adder's carry-out is the inverse of a borrow.
        carry_o = sub_i ? ~cout : cout;
        // Operands (as actually added) share a sign but the sum's sign differs.
        overflow_o = (a_i[WIDTH-1] == b_eff[WIDTH-1]) &&
                     (sum_ext[WIDTH-1] != a_i[WIDTH-1]);
        // Signed less-than: sign of the true difference, corrected for overflow.
        lt_signed_o   = sum_ext[WIDTH-1] ^ overflow_o;
        lt_unsigned_o = ~cout;
    end

endmodule : alu_addsub
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : Registered integer ALU. Twelve operations selected by Op are
//               computed combinationally and captured together with
//               zero/carry/overflow/illegal_op flags on the next rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] Op,
    output logic [WIDTH-1:0] Result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             illegal_op
);

    localparam int SH_W = $clog2(WIDTH);

    logic             legal;
    alu_op_e          op_e;
    logic [SH_W-1:0]  shamt;
    logic             sub_sel;

    logic [WIDTH-1:0] as_sum;
    logic             as_carry;
    logic             as_ovf;
    logic             as_lt_s;
    logic             as_lt_u;

    logic [WIDTH-1:0] result_d;
    logic             zero_d;
    logic             carry_d;
    logic             overflow_d;
    logic             illegal_d;

    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             carry_q;
    logic             overflow_q;
    logic             illegal_q;

    // Decode: legality uses the whole Op word, so any upper bit set is illegal.
    always_comb begin
        legal   = (Op <= WIDTH'(OP_LAST));
        op_e    = alu_op_e'(Op[3:0]);
        shamt   = B[SH_W-1:0];
        sub_sel = legal && ((op_e == OP_SUB) || (op_e == OP_SLT) ||
                            (op_e == OP_SLTU));
    end

    alu_addsub #(
        .WIDTH(WIDTH)
    ) u_addsub (
        .a_i          (A),
        .b_i          (B),
        .sub_i        (sub_sel),
        .sum_o        (as_sum),
        .carry_o      (as_carry),
        .overflow_o   (as_ovf),
        .lt_signed_o  (as_lt_s),
        .lt_unsigned_o(as_lt_u)
    );

    // Result mux and flag generation; every output has a defined default.
    always_comb begin
        result_d   = '0;
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        illegal_d  = ~legal;
        if (legal) begin
            case (op_e)
                OP_ADD, OP_SUB: begin
                    result_d   = as_sum;
                    carry_d    = as_carry;
                    overflow_d = as_ovf;
                end
                OP_AND:  result_d = A & B;
                OP_OR:   result_d = A | B;
                OP_XOR:  result_d = A ^ B;
                OP_NOR:  result_d = ~(A | B);
                OP_SLL:  result_d = A << shamt;
                OP_SRL:  result_d = A >> shamt;
                OP_SRA:  result_d = $unsigned($signed(A) >>> shamt);
                OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, as_lt_s};
                OP_SLTU: result_d = {{(WIDTH-1){1'b0}}, as_lt_u};
                OP_MUL:  result_d = A * B;
                default: result_d = '0;
            endcase
        end
        zero_d = legal && (result_d == '0);
    end

    // Single output register stage with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q   <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            result_q   <= result_d;
            zero_q     <= zero_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            illegal_q  <= illegal_d;
        end
    end

    assign Result     = result_q;
    assign zero       = zero_q;
    assign carry      = carry_q;
    assign overflow   = overflow_q;
    assign illegal_op = illegal_q;

endmodule : alu
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu
// Description : Self-checking bench for alu: directed boundary cases followed
//               by randomized operations compared against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        v;
        logic        ill;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] Op;
    logic [31:0] Result;
    logic        zero;
    logic        carry;
    logic        overflow;
    logic        illegal_op;

    int n_cmp;
    int n_err;

    alu #(
        .WIDTH(32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .Op        (Op),
        .Result    (Result),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow),
        .illegal_op(illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports.
    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model using plain 64-bit arithmetic.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] op);
        exp_t        e;
        logic [63:0] s;
        longint      sa;
        longint      sb;
        longint      sr;
        int          sh;
        e  = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b % 32);
        if (op > 32'd11) begin
            e.ill = 1'b1;
            return e;
        end
        case (op)
            32'd0: begin
                s     = {32'd0, a} + {32'd0, b};
                e.res = s[31:0];
                e.c   = s[32];
                sr    = sa + sb;
                e.v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            32'd1: begin
                e.res = a - b;
                e.c   = (a < b);
                sr    = sa - sb;
                e.v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            32'd2:  e.res = a & b;
            32'd3:  e.res = a | b;
            32'd4:  e.res = a ^ b;
            32'd5:  e.res = ~(a | b);
            32'd6:  e.res = a << sh;
            32'd7:  e.res = a >> sh;
            32'd8:  e.res = 32'(sa >> sh);
            32'd9:  e.res = (sa < sb) ? 32'd1 : 32'd0;
            32'd10: e.res = (a < b) ? 32'd1 : 32'd0;
            default: begin
                s     = {32'd0, a} * {32'd0, b};
                e.res = s[31:0];
            end
        endcase
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    // Drive one operation at the falling edge, check one cycle later.
    task automatic apply(input string tag, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] op,
                         input logic rn);
        exp_t e;
        @(negedge clk);
        A     = a;
        B     = b;
        Op    = op;
        rst_n = rn;
        e     = rn ? model(a, b, op) : '0;
        @(posedge clk);
        #1;
        check_eq({tag, ".res"}, Result, e.res);
        check_eq({tag, ".zero"}, {31'd0, zero}, {31'd0, e.z});
        check_eq({tag, ".carry"}, {31'd0, carry}, {31'd0, e.c});
        check_eq({tag, ".ovf"}, {31'd0, overflow}, {31'd0, e.v});
        check_eq({tag, ".ill"}, {31'd0, illegal_op}, {31'd0, e.ill});
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'(($urandom_range(0, 64)));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        A     = 32'd10;
        B     = 32'd5;
        Op    = 32'd0;

        // Reset held for two edges, then released.
        apply("rst0", 32'd10, 32'd5, 32'd0, 1'b0);
        apply("rst1", 32'd10, 32'd5, 32'd0, 1'b0);
        apply("rel", 32'd10, 32'd5, 32'd0, 1'b1);
        check_eq("rel.add15", Result, 32'd15);

        // Logic / arithmetic.
        apply("and", 32'd10, 32'd5, 32'd2, 1'b1);
        apply("sub", 32'd15, 32'd10, 32'd1, 1'b1);

        // Carry / overflow boundaries.
        apply("add_wrap", 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
        check_eq("add_wrap.c", {31'd0, carry}, 32'd1);
        apply("add_ovf", 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b1);
        check_eq("add_ovf.v", {31'd0, overflow}, 32'd1);
        apply("sub_ovf", 32'h8000_0000, 32'd1, 32'd1, 1'b1);
        apply("sub_brw", 32'd0, 32'd1, 32'd1, 1'b1);
        check_eq("sub_brw.r", Result, 32'hFFFF_FFFF);

        // Shifts / compares.
        apply("sra", 32'h8000_0000, 32'h24, 32'd8, 1'b1);
        check_eq("sra.r", Result, 32'hF800_0000);
        apply("srl", 32'h8000_0000, 32'h24, 32'd7, 1'b1);
        check_eq("srl.r", Result, 32'h0800_0000);
        apply("sll0", 32'h1234_5678, 32'h20, 32'd6, 1'b1);
        apply("slt", 32'hFFFF_FFFF, 32'd1, 32'd9, 1'b1);
        check_eq("slt.r", Result, 32'd1);
        apply("sltu", 32'hFFFF_FFFF, 32'd1, 32'd10, 1'b1);
        check_eq("sltu.r", Result, 32'd0);

        // Multiply / illegal.
        apply("mul_big", 32'h0001_0000, 32'h0001_0000, 32'd11, 1'b1);
        apply("mul_42", 32'd7, 32'd6, 32'd11, 1'b1);
        check_eq("mul_42.r", Result, 32'd42);
        apply("ill12", 32'd3, 32'd4, 32'd12, 1'b1);
        apply("ill100", 32'd3, 32'd4, 32'h100, 1'b1);
        check_eq("ill100.i", {31'd0, illegal_op}, 32'd1);

        // Back-to-back.
        apply("b2b_add", 32'd1, 32'd2, 32'd0, 1'b1);
        apply("b2b_xor", 32'hF0, 32'hFF, 32'd4, 1'b1);
        apply("b2b_nor", 32'd0, 32'd0, 32'd5, 1'b1);
        check_eq("b2b_nor.r", Result, 32'hFFFF_FFFF);

        // Mid-stream reset: the reset edge yields zero, next op is clean.
        apply("mid0", 32'd100, 32'd23, 32'd0, 1'b1);
        apply("mid_rst", 32'd9, 32'd9, 32'd4, 1'b0);
        apply("mid2", 32'd3, 32'd5, 32'd11, 1'b1);

        // Randomized operations, with occasional reset cycles.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] op;
            logic        rn;
            case ($urandom_range(0, 9))
                0:       op = $urandom;
                1:       op = 32'($urandom_range(12, 15));
                default: op = 32'($urandom_range(0, 11));
            endcase
            rn = ($urandom_range(0, 24) != 0);
            apply("rand", pick_operand(), pick_operand(), op, rn);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_alu
`default_nettype wire
